// File: rtl/sipo_deser_32bit_if.sv
// Handshake bundle for the serial-in/parallel-out deserializer.
// The deserializer itself uses the slave modport; the bit source and word sink use master.
interface sipo_deser_32bit_if #(
   parameter int WIDTH = 32
);
   logic             sin;
   logic             sin_valid;
   logic             sin_ready;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             word_ready;
   logic [5:0]       bit_count;

   modport master (
      output sin, sin_valid, word_ready,
      input  sin_ready, word, word_valid, bit_count
   );

   modport slave (
      input  sin, sin_valid, word_ready,
      output sin_ready, word, word_valid, bit_count
   );
endinterface

// File: rtl/sipo_deser_32bit.sv
// Double-buffered serial-to-parallel deserializer: bits pack into sh while the
// previous word is held on the output register until the downstream takes it.
module sipo_deser_32bit #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                clk,
   input logic                rst,
   sipo_deser_32bit_if.slave  bus
);
   localparam logic [0:0] S_FILL  = 1'b0;
   localparam logic [0:0] S_STALL = 1'b1;
   localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);
   localparam logic [5:0] CNT_FULL = 6'(WIDTH);

   logic [WIDTH-1:0] sh_reg, sh_next;
   logic [WIDTH-1:0] word_reg, word_next;
   logic [WIDTH-1:0] sh_shifted;
   logic [5:0]       cnt_reg, cnt_next;
   logic             word_valid_reg, word_valid_next;
   logic [0:0]       state_reg, state_next;

   // Shift register with the incoming bit inserted at the end selected by MSB_FIRST.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_in
               assign sh_shifted[gi] = bus.sin;
            end else begin : g_mv
               assign sh_shifted[gi] = sh_reg[gi-1];
            end
         end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_in
               assign sh_shifted[gi] = bus.sin;
            end else begin : g_mv
               assign sh_shifted[gi] = sh_reg[gi+1];
            end
         end
      end
   endgenerate

   always_comb begin
      sh_next         = sh_reg;
      word_next       = word_reg;
      cnt_next        = cnt_reg;
      word_valid_next = word_valid_reg;
      state_next      = state_reg;
      case (state_reg)
         S_FILL: begin
            if (word_valid_reg && bus.word_ready) begin
               word_valid_next = 1'b0;
            end
            if (bus.sin_valid) begin
               sh_next  = sh_shifted;
               cnt_next = cnt_reg + 6'd1;
               if (cnt_reg == CNT_LAST) begin
                  if (!word_valid_reg || bus.word_ready) begin
                     word_next       = sh_shifted;
                     word_valid_next = 1'b1;
                     cnt_next        = 6'd0;
                  end else begin
                     // Output slot busy: park the finished word in sh and stop accepting.
                     cnt_next   = CNT_FULL;
                     state_next = S_STALL;
                  end
               end
            end
         end
         default: begin
            if (bus.word_ready) begin
               word_next  = sh_reg;
               cnt_next   = 6'd0;
               state_next = S_FILL;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_reg         <= '0;
         word_reg       <= '0;
         cnt_reg        <= 6'd0;
         word_valid_reg <= 1'b0;
         state_reg      <= S_FILL;
      end else begin
         sh_reg         <= sh_next;
         word_reg       <= word_next;
         cnt_reg        <= cnt_next;
         word_valid_reg <= word_valid_next;
         state_reg      <= state_next;
      end
   end

   assign bus.sin_ready  = (state_reg == S_FILL);
   assign bus.word       = word_reg;
   assign bus.word_valid = word_valid_reg;
   assign bus.bit_count  = cnt_reg;
endmodule

// File: tb/tb_sipo_deser_32bit.sv
// Bench for sipo_deser_32bit: an MSB-first and an LSB-first instance share one stimulus
// stream and are compared every cycle against a bit-queue reference model.
module tb_sipo_deser_32bit;
   logic clk;
   logic rst;

   sipo_deser_32bit_if #(.WIDTH(32)) bm ();
   sipo_deser_32bit_if #(.WIDTH(32)) bl ();

   sipo_deser_32bit #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(bm));
   sipo_deser_32bit #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bl));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: bits collected so far, plus the presented word for each ordering.
   bit          q[$];
   logic [31:0] mw_msb = '0;
   logic [31:0] mw_lsb = '0;
   bit          mvalid = 1'b0;

   function automatic logic [31:0] pack(input bit msb);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < q.size(); i++) begin
         if (msb) r[31-i] = q[i];
         else     r[i]    = q[i];
      end
      return r;
   endfunction

   task automatic model_step(input logic s, input logic sv, input logic wr, input logic r);
      bit was_valid;
      if (r) begin
         q.delete();
         mw_msb = '0;
         mw_lsb = '0;
         mvalid = 1'b0;
      end else begin
         was_valid = mvalid;
         if (q.size() == 32) begin
            if (wr) begin
               mw_msb = pack(1'b1);
               mw_lsb = pack(1'b0);
               q.delete();
            end
         end else begin
            if (was_valid && wr) mvalid = 1'b0;
            if (sv) begin
               q.push_back(s);
               if (q.size() == 32 && (!was_valid || wr)) begin
                  mw_msb = pack(1'b1);
                  mw_lsb = pack(1'b0);
                  mvalid = 1'b1;
                  q.delete();
               end
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [31:0] cnt_exp;
      logic [31:0] rdy_exp;
      cnt_exp = 32'(q.size());
      rdy_exp = {31'd0, (q.size() < 32)};
      chk("msb.word",       bm.word,                mw_msb);
      chk("msb.word_valid", {31'd0, bm.word_valid}, {31'd0, mvalid});
      chk("msb.sin_ready",  {31'd0, bm.sin_ready},  rdy_exp);
      chk("msb.bit_count",  {26'd0, bm.bit_count},  cnt_exp);
      chk("lsb.word",       bl.word,                mw_lsb);
      chk("lsb.word_valid", {31'd0, bl.word_valid}, {31'd0, mvalid});
      chk("lsb.sin_ready",  {31'd0, bl.sin_ready},  rdy_exp);
      chk("lsb.bit_count",  {26'd0, bl.bit_count},  cnt_exp);
   endtask

   task automatic cycle(input logic s, input logic sv, input logic wr, input logic r);
      bm.sin = s;  bm.sin_valid = sv;  bm.word_ready = wr;
      bl.sin = s;  bl.sin_valid = sv;  bl.word_ready = wr;
      rst = r;
      @(posedge clk);
      model_step(s, sv, wr, r);
      #1;
      check_all();
   endtask

   // Sends 32 bits of v, highest bit first unless lsb_order; optional idle cycle between bits.
   task automatic send_word(input logic [31:0] v, input bit lsb_order, input bit gaps,
                            input logic wr_body, input logic wr_last);
      for (int i = 0; i < 32; i++) begin
         cycle(lsb_order ? v[i] : v[31-i], 1'b1, (i == 31) ? wr_last : wr_body, 1'b0);
         if (gaps && i != 31) cycle(1'($urandom), 1'b0, wr_body, 1'b0);
      end
      $display("sent word %08h lsb_order=%0d gaps=%0d -> msb=%08h lsb=%08h valid=%0d",
               v, lsb_order, gaps, bm.word, bl.word, bm.word_valid);
   endtask

   typedef struct {
      logic [31:0] value;
      bit          lsb_order;
      bit          gaps;
      logic [31:0] exp_msb;
      logic [31:0] exp_lsb;
   } vec_t;

   vec_t tbl[4];

   initial begin
      tbl[0] = '{32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 32'hF77DB57B};
      tbl[1] = '{32'h12345678, 1'b1, 1'b0, 32'h1E6A2C48, 32'h12345678};
      tbl[2] = '{32'h0F0F0F0F, 1'b0, 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0};
      tbl[3] = '{32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D, 32'hB00F7F53};

      rst = 1'b1;
      bm.sin = 1'b0; bm.sin_valid = 1'b0; bm.word_ready = 1'b0;
      bl.sin = 1'b0; bl.sin_valid = 1'b0; bl.word_ready = 1'b0;
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset.word",      bm.word,                32'h0);
      chk("reset.valid",     {31'd0, bm.word_valid}, 32'h0);
      chk("reset.sin_ready", {31'd0, bm.sin_ready},  32'h1);
      chk("reset.count",     {26'd0, bm.bit_count},  32'h0);

      // Table: complete words with word_ready held high.
      for (int k = 0; k < 4; k++) begin
         send_word(tbl[k].value, tbl[k].lsb_order, tbl[k].gaps, 1'b1, 1'b1);
         chk("tbl.msb_word", bm.word, tbl[k].exp_msb);
         chk("tbl.lsb_word", bl.word, tbl[k].exp_lsb);
         chk("tbl.valid",    {31'd0, bm.word_valid}, 32'h1);
         chk("tbl.count",    {26'd0, bm.bit_count},  32'h0);
         cycle(1'b0, 1'b0, 1'b1, 1'b0);
         chk("tbl.valid_drop", {31'd0, bm.word_valid}, 32'h0);
      end

      // Backpressure: second word parks in the shift register.
      send_word(32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("stall.word",      bm.word,               32'hAAAAAAAA);
      chk("stall.sin_ready", {31'd0, bm.sin_ready}, 32'h0);
      chk("stall.count",     {26'd0, bm.bit_count}, 32'd32);
      for (int i = 0; i < 4; i++) cycle(1'($urandom), 1'b1, 1'b0, 1'b0);
      chk("stall.ignored", {26'd0, bm.bit_count}, 32'd32);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      $display("stall release -> word=%08h valid=%0d ready=%0d count=%0d",
               bm.word, bm.word_valid, bm.sin_ready, bm.bit_count);
      chk("release.word",      bm.word,                32'h55555555);
      chk("release.valid",     {31'd0, bm.word_valid}, 32'h1);
      chk("release.sin_ready", {31'd0, bm.sin_ready},  32'h1);
      chk("release.count",     {26'd0, bm.bit_count},  32'h0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of a word discards the partial bits.
      for (int i = 0; i < 10; i++) cycle(1'($urandom), 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("midrst.count",     {26'd0, bm.bit_count},  32'h0);
      chk("midrst.word",      bm.word,                32'h0);
      chk("midrst.valid",     {31'd0, bm.word_valid}, 32'h0);
      chk("midrst.sin_ready", {31'd0, bm.sin_ready},  32'h1);
      send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("midrst.clean_msb", bm.word, 32'hCAFEF00D);
      chk("midrst.clean_lsb", bl.word, 32'hB00F7F53);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Consume and completing bit on the same edge: no bubble, no stall.
      send_word(32'h13579BDF, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(32'h2468ACE0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("swap.word",      bm.word,                32'h2468ACE0);
      chk("swap.valid",     {31'd0, bm.word_valid}, 32'h1);
      chk("swap.sin_ready", {31'd0, bm.sin_ready},  32'h1);
      chk("swap.count",     {26'd0, bm.bit_count},  32'h0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom), ($urandom_range(3) != 0), 1'($urandom),
               ($urandom_range(199) == 0));
      end
      $display("random phase done, last word msb=%08h lsb=%08h", bm.word, bl.word);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
